// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
// Groups the datapath-side request bus and the SRAM-side bus of the memory
// access controller.
//   master : the datapath/SRAM environment. It drives the request, the address,
//            the write data, the switches and the SRAM read data.
//   slave  : the controller. It drives the read data, R/Busy, the SRAM
//            address/data/strobes and the HEX output register.
interface mem_access_ctrl_if;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [15:0] MAR;
  logic [15:0] MDR;
  logic [15:0] Switches;
  logic [15:0] Data_from_SRAM;
  logic [15:0] MDR_In;
  logic        R;
  logic        Busy;
  logic [19:0] ADDR;
  logic [15:0] Data_to_SRAM;
  logic        CE_N;
  logic        OE_N;
  logic        WE_N;
  logic        UB_N;
  logic        LB_N;
  logic [15:0] HEX_Data;

  modport master (
    output MEM_REQ, MEM_WE, MAR, MDR, Switches, Data_from_SRAM,
    input  MDR_In, R, Busy, ADDR, Data_to_SRAM,
    input  CE_N, OE_N, WE_N, UB_N, LB_N, HEX_Data
  );

  modport slave (
    input  MEM_REQ, MEM_WE, MAR, MDR, Switches, Data_from_SRAM,
    output MDR_In, R, Busy, ADDR, Data_to_SRAM,
    output CE_N, OE_N, WE_N, UB_N, LB_N, HEX_Data
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Sequences one memory transfer at a time between the datapath and an
// asynchronous SRAM, and handles one memory-mapped I/O address (16'hFFFF).
// At that address a read returns Switches and a write loads HEX_Data.
// Ports:
//   Clk   : system clock. All state changes on its rising edge.
//   Reset : synchronous, active-low reset.
//   bus   : slave side of mem_access_ctrl_if.
//           Request side:  MEM_REQ, MEM_WE, MAR, MDR and Switches.
//           SRAM side:     Data_from_SRAM, ADDR, Data_to_SRAM and the
//                          CE_N/OE_N/WE_N/UB_N/LB_N strobes.
//           Returned data: MDR_In, R (done pulse), Busy and HEX_Data.
// Parameter:
//   WAIT_CYCLES : number of ACCESS cycles per SRAM transfer (1..15).
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic              Clk,
  input logic              Reset,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  localparam logic [3:0]  CNT_LOAD = 4'(WAIT_CYCLES - 1);
  localparam logic [15:0] IO_ADDR  = 16'hFFFF;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        we_q, we_d;
  logic [15:0] mdr_in_q, mdr_in_d;
  logic [15:0] hex_q, hex_d;
  logic        ce_n;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'h0;
      addr_q   <= 16'h0;
      data_q   <= 16'h0;
      we_q     <= 1'b0;
      mdr_in_q <= 16'h0;
      hex_q    <= 16'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      mdr_in_q <= mdr_in_d;
      hex_q    <= hex_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = we_q;
    mdr_in_d = mdr_in_q;
    hex_d    = hex_q;
    case (state_q)
      IDLE: begin
        if (bus.MEM_REQ) begin
          addr_d = bus.MAR;
          data_d = bus.MDR;
          we_d   = bus.MEM_WE;
          // The I/O address never reaches the SRAM. It completes in one cycle.
          if (bus.MAR == IO_ADDR) begin
            if (bus.MEM_WE) hex_d    = bus.MDR;
            else            mdr_in_d = bus.Switches;
            state_d = DONE;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        cnt_d   = CNT_LOAD;
        state_d = ACCESS;
      end
      ACCESS: begin
        // The counter starts at WAIT_CYCLES-1, so ACCESS lasts exactly
        // WAIT_CYCLES cycles.
        if (cnt_q == 4'h0) begin
          if (!we_q) mdr_in_d = bus.Data_from_SRAM;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'h1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ce_n = !((state_q == SETUP) || (state_q == ACCESS));

  // OE is asserted for reads only and WE only in ACCESS of a write.
  // The two enables are therefore never low together.
  assign bus.CE_N         = ce_n;
  assign bus.OE_N         = ce_n | we_q;
  assign bus.WE_N         = !((state_q == ACCESS) && we_q);
  assign bus.UB_N         = ce_n;
  assign bus.LB_N         = ce_n;
  assign bus.ADDR         = ce_n ? 20'h0 : {4'h0, addr_q};
  assign bus.Data_to_SRAM = (!ce_n && we_q) ? data_q : 16'h0;
  assign bus.R            = (state_q == DONE);
  assign bus.Busy         = (state_q != IDLE);
  assign bus.MDR_In       = mdr_in_q;
  assign bus.HEX_Data     = hex_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  typedef struct {
    int          lat;
    logic [15:0] mdr;
    logic [15:0] hex;
  } sb_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  sb_t sbq[$];

  logic        sel = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we = 1'b0, use_model = 1'b0;
  logic [15:0] mar = 16'h0, mdr = 16'h0, sw = 16'h0, dsram = 16'h0;
  logic [15:0] mdr_m[2];
  logic [15:0] hex_m[2];

  mem_access_ctrl_if b0();
  mem_access_ctrl_if b1();

  assign b0.MEM_REQ = req0;
  assign b0.MEM_WE = we;
  assign b0.MAR = mar;
  assign b0.MDR = mdr;
  assign b0.Switches = sw;
  assign b0.Data_from_SRAM = use_model ? (b0.ADDR[15:0] ^ 16'h5A5A) : dsram;
  assign b1.MEM_REQ = req1;
  assign b1.MEM_WE = we;
  assign b1.MAR = mar;
  assign b1.MDR = mdr;
  assign b1.Switches = sw;
  assign b1.Data_from_SRAM = dsram;

  mem_access_ctrl #(.WAIT_CYCLES(2)) dut0 (.Clk(Clk), .Reset(Reset), .bus(b0.slave));
  mem_access_ctrl #(.WAIT_CYCLES(1)) dut1 (.Clk(Clk), .Reset(Reset), .bus(b1.slave));

  logic        m_r, m_busy, m_ce_n, m_oe_n, m_we_n, m_ub_n, m_lb_n;
  logic [19:0] m_addr;
  logic [15:0] m_dts, m_mdr_in, m_hex;

  always_comb begin
    if (sel) begin
      m_r = b1.R;
      m_busy = b1.Busy;
      m_ce_n = b1.CE_N;
      m_oe_n = b1.OE_N;
      m_we_n = b1.WE_N;
      m_ub_n = b1.UB_N;
      m_lb_n = b1.LB_N;
      m_addr = b1.ADDR;
      m_dts = b1.Data_to_SRAM;
      m_mdr_in = b1.MDR_In;
      m_hex = b1.HEX_Data;
    end else begin
      m_r = b0.R;
      m_busy = b0.Busy;
      m_ce_n = b0.CE_N;
      m_oe_n = b0.OE_N;
      m_we_n = b0.WE_N;
      m_ub_n = b0.UB_N;
      m_lb_n = b0.LB_N;
      m_addr = b0.ADDR;
      m_dts = b0.Data_to_SRAM;
      m_mdr_in = b0.MDR_In;
      m_hex = b0.HEX_Data;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One transfer. The expected completion is pushed when the request is driven
  // and popped when R appears. MAR/MDR are corrupted right after acceptance.
  task automatic xfer(input logic s, input logic w, input logic [15:0] a,
                      input logic [15:0] d, input int lat, input string name);
    sb_t e;
    int  wen_cnt = 0, cen_cnt = 0, oen_cnt = 0, wc;
    bit  got = 0, sram;
    wc   = s ? 1 : 2;
    sram = (a != 16'hFFFF);
    if (!sram) begin
      if (w) hex_m[s] = d;
      else   mdr_m[s] = sw;
    end else if (!w) begin
      mdr_m[s] = dsram;
    end
    e.lat = lat;
    e.mdr = mdr_m[s];
    e.hex = hex_m[s];
    sbq.push_back(e);
    sel = s;
    we = w;
    mar = a;
    mdr = d;
    if (s) req1 = 1'b1;
    else   req0 = 1'b1;
    for (int c = 1; c <= lat + 3 && !got; c++) begin
      tick();
      req0 = 1'b0;
      req1 = 1'b0;
      mar = ~a;
      mdr = ~d;
      if (!m_ce_n) begin
        cen_cnt++;
        checks++;
        if (m_addr !== {4'h0, a} || m_ub_n !== 1'b0 || m_lb_n !== 1'b0) begin
          errors++;
          $display("FAIL %s addr/ub/lb: got %h %b %b, want %h 0 0", name, m_addr, m_ub_n, m_lb_n, {4'h0, a});
        end
      end
      if (!m_oe_n) oen_cnt++;
      if (!m_we_n) begin
        wen_cnt++;
        checks++;
        if (m_dts !== d || !m_oe_n) begin
          errors++;
          $display("FAIL %s wdata: got %h oe_n=%b, want %h oe_n=1", name, m_dts, m_oe_n, d);
        end
      end
      if (m_r) begin
        got = 1;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected R at +%0d", name, c);
        end else begin
          e = sbq.pop_front();
          if (c != e.lat || m_mdr_in !== e.mdr || m_hex !== e.hex || m_ce_n !== 1'b1 || m_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s done: got lat=%0d mdr=%h hex=%h ce_n=%b busy=%b, want lat=%0d mdr=%h hex=%h ce_n=1 busy=1",
                     name, c, m_mdr_in, m_hex, m_ce_n, m_busy, e.lat, e.mdr, e.hex);
          end
        end
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout: got no R, want R at +%0d", name, lat);
      void'(sbq.pop_front());
    end
    checks++;
    if (wen_cnt != ((sram && w) ? wc : 0) || cen_cnt != (sram ? wc + 1 : 0) ||
        oen_cnt != ((sram && !w) ? wc + 1 : 0)) begin
      errors++;
      $display("FAIL %s strobe counts: got we=%0d ce=%0d oe=%0d, want we=%0d ce=%0d oe=%0d", name,
               wen_cnt, cen_cnt, oen_cnt, (sram && w) ? wc : 0, sram ? wc + 1 : 0, (sram && !w) ? wc + 1 : 0);
    end
    tick();
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (m_busy !== 1'b0 || m_r !== 1'b0 || {m_ce_n, m_oe_n, m_we_n, m_ub_n, m_lb_n} !== 5'b11111 ||
        m_addr !== 20'h0 || m_dts !== 16'h0 || m_mdr_in !== mdr_m[sel] || m_hex !== hex_m[sel]) begin
      errors++;
      $display("FAIL %s: got busy=%b r=%b strb=%b addr=%h dts=%h mdr=%h hex=%h, want 0 0 11111 0 0 %h %h",
               name, m_busy, m_r, {m_ce_n, m_oe_n, m_we_n, m_ub_n, m_lb_n}, m_addr, m_dts, m_mdr_in, m_hex,
               mdr_m[sel], hex_m[sel]);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    mdr_m[0] = 16'h0;
    mdr_m[1] = 16'h0;
    hex_m[0] = 16'h0;
    hex_m[1] = 16'h0;
    sel = 1'b0;
    check_idle("reset_dut0");
    sel = 1'b1;
    check_idle("reset_dut1");
  endtask

  task automatic test_sram_read();
    dsram = 16'hBEEF;
    xfer(1'b0, 1'b0, 16'h0042, 16'h1111, 4, "sram_read");
  endtask

  task automatic test_sram_write();
    dsram = 16'hDEAD;
    xfer(1'b0, 1'b1, 16'h1234, 16'hA5A5, 4, "sram_write");
    check_idle("write_keeps_mdr");
  endtask

  task automatic test_io();
    sw = 16'h1111;
    xfer(1'b0, 1'b1, 16'hFFFF, 16'h0C0D, 1, "io_write");
    sw = 16'h00F3;
    xfer(1'b0, 1'b0, 16'hFFFF, 16'h7777, 1, "io_read");
    check_idle("io_after");
  endtask

  // Request held for 20 cycles with MAR changing every cycle. Only the MAR of
  // each accepted cycle (every fifth) may reach the SRAM.
  task automatic test_back_to_back();
    sb_t e;
    int  npulse = 0;
    sel = 1'b0;
    use_model = 1'b1;
    we = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      if (b0.R) begin
        npulse++;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL held extra R at cycle %0d", c);
        end else begin
          e = sbq.pop_front();
          if (c != e.lat || b0.MDR_In !== e.mdr) begin
            errors++;
            $display("FAIL held R: got cycle=%0d mdr=%h, want cycle=%0d mdr=%h", c, b0.MDR_In, e.lat, e.mdr);
          end
        end
      end
      if (c < 20) begin
        mar = 16'h0100 + 16'(c);
        req0 = 1'b1;
        if (c % 5 == 0) begin
          e.lat = c + 4;
          e.mdr = mar ^ 16'h5A5A;
          e.hex = hex_m[0];
          mdr_m[0] = e.mdr;
          sbq.push_back(e);
        end
      end else begin
        req0 = 1'b0;
      end
      tick();
    end
    use_model = 1'b0;
    checks++;
    if (npulse != 4 || sbq.size() != 0) begin
      errors++;
      $display("FAIL held count: got %0d pulses %0d pending, want 4 pulses 0 pending", npulse, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    sel = 1'b0;
    we = 1'b0;
    mar = 16'h0321;
    dsram = 16'h4444;
    req0 = 1'b1;
    tick();
    req0 = 1'b0;
    tick();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    mdr_m[0] = 16'h0;
    hex_m[0] = 16'h0;
    check_idle("reset_mid");
    for (int c = 0; c < 8; c++) begin
      if (m_r || !m_ce_n || !m_oe_n || !m_we_n) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || m_mdr_in !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid quiet: got %0d active cycles mdr=%h, want 0 cycles mdr=0000", bad, m_mdr_in);
    end
  endtask

  task automatic test_wait1();
    dsram = 16'h1357;
    xfer(1'b1, 1'b0, 16'h0ABC, 16'h0, 3, "wait1_read");
    check_idle("wait1_after");
  endtask

  initial begin
    test_reset();
    test_sram_read();
    test_sram_write();
    test_io();
    test_back_to_back();
    test_reset_mid();
    test_wait1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
